fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch + IF/ID pipeline register for the WISC-SP19 core. Drives PC and
//  requests words from a stalling instruction memory, buffers returned words in a
//  one-entry skid buffer, and presents instr/PC+2 to decode; instr[15:11] feeds the
//  control decoder. Handles hazard stall, branch/jump redirect with flush, and HALT.
// PARAMETERS
//  ADDR_W    16       PC / imem address width
//  INSTR_W   16       instruction width
//  RESET_PC  16'h0000 first fetch address after reset
// PORTS
//  clk            in   1        system clock; all state on rising edge
//  rst            in   1        asynchronous, active-high reset
//  imem_req       out  1        fetch request; held with imem_addr stable until imem_ready
//  imem_addr      out  ADDR_W   fetch address
//  imem_ready     in   1        request complete; imem_rdata valid this cycle
//  imem_rdata     in   INSTR_W  fetched instruction word
//  stall_id       in   1        decode cannot accept; IF/ID holds
//  redirect_valid in   1        branch/jump taken; flush and refetch
//  redirect_pc    in   ADDR_W   new fetch address
//  ifid_valid     out  1        IF/ID holds a real instruction (else bubble)
//  ifid_instr     out  INSTR_W  instruction to decode
//  ifid_opcode    out  5        ifid_instr[15:11], to control decoder
//  ifid_pc2       out  ADDR_W   address of ifid_instr + 2
//  halted         out  1        HALT delivered; fetch stopped
// BEHAVIOUR
//  - Reset: imem_req=0, imem_addr=0, ifid_valid=0, ifid_instr=0, ifid_pc2=0, halted=0,
//    fetch_pc=RESET_PC, skid empty, drop=0, state FETCH. First request cycle after reset.
//  - State: FETCH, HALTED. Regs: fetch_pc, req_addr, busy, drop, skid{valid,instr,pc2}.
//  - Issue (FETCH, !busy, skid empty, !redirect): busy<=1, req_addr<=fetch_pc.
//    imem_req=busy, imem_addr=req_addr; back-to-back issue allowed in ready cycle.
//  - Response (busy & imem_ready): busy<=0. If drop: discard, drop<=0. Else word with
//    pc2=req_addr+2 (mod 2^ADDR_W, FFFE->0000) is delivered; fetch_pc<=req_addr+2.
//  - IF/ID load when !stall_id: skid entry if valid (skid cleared), else delivered word,
//    else bubble (ifid_valid=0). stall_id=1: IF/ID holds; delivered word -> skid.
//    Skid never overflows: no issue while skid full.
//  - Redirect (highest priority, ignores stall_id): ifid_valid<=0, skid cleared,
//    fetch_pc<=redirect_pc, state<=FETCH, halted<=0. If busy and !imem_ready: drop<=1
//    (req/addr stay stable until ready). Response in same cycle is discarded directly.
//  - HALT: delivered word with [15:11]==5'b00000 -> state HALTED, halted<=1 same edge
//    word enters IF/ID or skid; no further issue. Halt word still passes to decode.
//    Only redirect or reset leaves HALTED. In-flight request at HALT: none (halt
//    detected at delivery, issue of next is suppressed that cycle).
//  - Latency: issue->ready N cycles (memory), ready->IF/ID 1 edge if not stalled.
//  - Throughput: 1 instr/cycle with zero-wait memory, no stalls.
//  - rst mid-request: all state cleared; imem_req drops asynchronously.
// STRUCTURE
//  - Shared header wisc_defs.vh: OPC_HALT=5'b00000, INSTR_W, ADDR_W, PC_INC=2.
//  - Sub-module fetch_skid_buf: one-entry buffer {valid,instr,pc2}, load/unload/flush.
//  - fetch_stage holds FSM, fetch_pc/req_addr/busy/drop, IF/ID register.
// TESTING
//  1 Zero-wait mem, RESET_PC=0, words 0x4000,0x4000.. -> ifid_pc2 2,4,6 one per
//    cycle from 2nd cycle after reset; ifid_opcode=5'b01000.
//  2 stall_id high 3 cycles mid-stream -> IF/ID held, one word in skid, imem_req low
//    while skid full; no word lost/duplicated after release.
//  3 imem_ready delayed 4 cycles, redirect_valid pc=0x0100 in cycle 2 -> imem_addr
//    stable until ready, data dropped, next imem_addr=0x0100, ifid_valid=0 meanwhile.
//  4 Word 0x0000 at addr 0x0008 -> ifid_instr=0x0000, ifid_pc2=0x000A, halted=1,
//    no further imem_req; redirect to 0x0020 -> halted=0, fetch resumes at 0x0020.
//  5 RESET_PC=16'hFFFE -> ifid_pc2=0x0000, next imem_addr=0x0000.
//  6 rst asserted while busy -> imem_req=0, ifid_valid=0 immediately; refetch RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage of the WISC-SP19 core.
//   OPC_HALT      : opcode field value that stops fetch
//   PC_INC        : byte distance between consecutive instructions
//   fetch_state_e : fetch controller states
package fetch_stage_pkg;

  localparam logic [4:0] OPC_HALT = 5'b00000;
  localparam int         PC_INC   = 2;

  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word while decode is stalled.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture in_instr/in_pc2 (entry becomes valid)
//   unload    : entry consumed by the IF/ID register
//   flush     : discard the entry (redirect); wins over load/unload
//   in_instr, in_pc2 : word and its PC+2 to capture
//   valid, instr, pc2 : current entry
module fetch_skid_buf #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               unload,
  input  logic               flush,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc2,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc2
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc2_q, pc2_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc2_d   = pc2_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = in_instr;
      pc2_d   = in_pc2;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc2_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc2_q   <= pc2_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc2   = pc2_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID pipeline register for the WISC-SP19 core.
// Issues one request at a time to a stalling instruction memory, parks a word
// in a one-entry skid buffer while decode stalls, handles redirect/flush and HALT.
//   clk, rst                  : clock, asynchronous active-high reset
//   imem_req/imem_addr        : fetch request, held stable until imem_ready
//   imem_ready/imem_rdata     : request completion and returned word
//   stall_id                  : decode cannot accept, IF/ID holds
//   redirect_valid/redirect_pc: taken branch/jump, flush and refetch
//   ifid_valid/instr/opcode/pc2 : IF/ID register contents to decode
//   halted                    : HALT delivered, fetch stopped
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall_id,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [4:0]         ifid_opcode,
  output logic [ADDR_W-1:0]  ifid_pc2,
  output logic               halted
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic               busy_q, busy_d;
  logic               drop_q, drop_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]  ifid_pc2_q, ifid_pc2_d;

  logic               resp, deliver, is_halt, issue, fetch_en;
  logic [ADDR_W-1:0]  deliv_pc2;
  logic               skid_valid, skid_load, skid_unload;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc2;

  assign resp      = busy_q & imem_ready;
  // A response in a redirect cycle is wrong-path and is discarded outright.
  assign deliver   = resp & ~drop_q & ~redirect_valid;
  assign deliv_pc2 = req_addr_q + ADDR_W'(PC_INC);
  assign is_halt   = deliver & (imem_rdata[INSTR_W-1 -: 5] == OPC_HALT);

  // Issue also in the ready cycle for back-to-back fetch. Hold off when the
  // delivered word is about to park in the skid, otherwise the next response
  // could arrive with the skid still full.
  assign issue = fetch_en & (~busy_q | resp) & ~skid_valid & ~redirect_valid &
                 ~is_halt & ~(deliver & stall_id);

  assign skid_load   = deliver & stall_id;
  assign skid_unload = skid_valid & ~stall_id & ~redirect_valid;

  fetch_skid_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .unload   (skid_unload),
    .flush    (redirect_valid),
    .in_instr (imem_rdata),
    .in_pc2   (deliv_pc2),
    .valid    (skid_valid),
    .instr    (skid_instr),
    .pc2      (skid_pc2)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (redirect_valid)  state_d = ST_FETCH;
    else if (is_halt)    state_d = ST_HALTED;
  end

  // FSM: outputs
  always_comb begin
    fetch_en = (state_q == ST_FETCH);
    halted   = (state_q == ST_HALTED);
  end

  always_comb begin
    busy_d       = busy_q;
    drop_d       = drop_q;
    fetch_pc_d   = fetch_pc_q;
    req_addr_d   = req_addr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc2_d   = ifid_pc2_q;

    if (resp) begin
      busy_d = 1'b0;
      drop_d = 1'b0;
    end
    if (deliver) fetch_pc_d = deliv_pc2;
    if (issue) begin
      busy_d     = 1'b1;
      // fetch_pc_q has not yet advanced past the word delivered this cycle
      req_addr_d = deliver ? deliv_pc2 : fetch_pc_q;
    end

    if (redirect_valid) begin
      ifid_valid_d = 1'b0;
      fetch_pc_d   = redirect_pc;
      // Request still outstanding: keep it on the bus, discard its data later
      if (busy_q & ~imem_ready) drop_d = 1'b1;
    end else if (!stall_id) begin
      if (skid_valid) begin
        ifid_valid_d = 1'b1;
        ifid_instr_d = skid_instr;
        ifid_pc2_d   = skid_pc2;
      end else if (deliver) begin
        ifid_valid_d = 1'b1;
        ifid_instr_d = imem_rdata;
        ifid_pc2_d   = deliv_pc2;
      end else begin
        ifid_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      req_addr_q   <= '0;
      busy_q       <= 1'b0;
      drop_q       <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc2_q   <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      req_addr_q   <= req_addr_d;
      busy_q       <= busy_d;
      drop_q       <= drop_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc2_q   <= ifid_pc2_d;
    end
  end

  assign imem_req    = busy_q;
  assign imem_addr   = req_addr_q;
  assign ifid_valid  = ifid_valid_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_opcode = ifid_instr_q[INSTR_W-1 -: 5];
  assign ifid_pc2    = ifid_pc2_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ready;
  logic [15:0] imem_addr, imem_rdata;
  logic        stall_id = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        ifid_valid, halted;
  logic [15:0] ifid_instr, ifid_pc2;
  logic [4:0]  ifid_opcode;

  // second instance, RESET_PC at the top of the address space
  logic        req_w, valid_w, halted_w;
  logic [15:0] addr_w, instr_w, pc2_w;
  logic [4:0]  opc_w;

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall_id(stall_id),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_opcode(ifid_opcode),
    .ifid_pc2(ifid_pc2), .halted(halted)
  );

  fetch_stage #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'hFFFE)) u_dut_w (
    .clk(clk), .rst(rst), .imem_req(req_w), .imem_addr(addr_w),
    .imem_ready(req_w), .imem_rdata(16'h4000), .stall_id(1'b0),
    .redirect_valid(1'b0), .redirect_pc(16'h0000),
    .ifid_valid(valid_w), .ifid_instr(instr_w), .ifid_opcode(opc_w),
    .ifid_pc2(pc2_w), .halted(halted_w)
  );

  // memory model: ready after lat wait cycles, word indexed by addr[8:1]
  logic [15:0] mem [0:255];
  int          lat = 0;
  int          wait_cnt = 0;

  assign imem_ready = imem_req && (wait_cnt == lat);
  assign imem_rdata = mem[imem_addr[8:1]];

  always @(posedge clk or posedge rst) begin
    if (rst || !imem_req || imem_ready) wait_cnt <= 0;
    else                                wait_cnt <= wait_cnt + 1;
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } exp_t;
  exp_t sb_q[$];

  // scoreboard: each word accepted by decode must match the next expected one
  logic        pend = 1'b0;
  logic [15:0] pend_addr = 16'h0;
  always @(negedge clk) begin
    if (rst) begin
      pend <= 1'b0;
    end else begin
      if (pend) chk("addr_hold", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, pend_addr});
      pend      <= imem_req && !imem_ready;
      pend_addr <= imem_addr;
      if (ifid_valid && !stall_id && !redirect_valid && sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("ifid_instr", {16'd0, ifid_instr}, {16'd0, e.instr});
        chk("ifid_pc2", {16'd0, ifid_pc2}, {16'd0, e.pc2});
        chk("ifid_opcode", {27'd0, ifid_opcode}, {27'd0, e.instr[15:11]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input bit seq);
    for (int i = 0; i < 256; i++) mem[i] = seq ? (16'h4000 + 16'(i)) : 16'h4000;
  endtask

  task automatic push_seq(input logic [15:0] start, input int n);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = start + 16'(2 * i);
      sb_q.push_back({mem[a[8:1]], a + 16'd2});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall_id = 1'b0;
    redirect_valid = 1'b0;
    sb_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, sb_q.size(), 0);
  endtask

  // wait for a request on a nonzero address, checking decode sees only bubbles
  task automatic wait_new_req(input string tag, input int budget);
    int n = 0;
    while (!(imem_req && imem_addr != 16'h0) && n < budget) begin
      chk({tag, "_bubble"}, {31'd0, ifid_valid}, 32'd0);
      tick();
      n++;
    end
  endtask

  initial begin
    bit found;
    // reset state
    fill_mem(1'b0);
    lat = 0;
    rst = 1'b1;
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", {16'd0, imem_addr}, 32'd0);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_instr", {16'd0, ifid_instr}, 32'd0);
    chk("rst_pc2", {16'd0, ifid_pc2}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    // 1: zero-wait stream of 0x4000, one per cycle from second edge
    do_reset();
    push_seq(16'h0000, 8);
    tick();
    chk("t1_req", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'h0000});
    chk("t1_first_bubble", {31'd0, ifid_valid}, 32'd0);
    tick();
    chk("t1_first_valid", {31'd0, ifid_valid}, 32'd1);
    chk("t1_back2back", {16'd0, imem_addr}, 32'h0002);
    for (int i = 0; i < 8; i++) tick();
    chk("t1_rate", sb_q.size(), 0);

    // 2: stall with skid
    fill_mem(1'b1);
    do_reset();
    push_seq(16'h0000, 12);
    for (int i = 0; i < 4; i++) tick();
    stall_id = 1'b1;
    tick();
    chk("t2_req_low", {31'd0, imem_req}, 32'd0);
    chk("t2_hold", {16'd0, ifid_pc2}, 32'h0006);
    tick();
    chk("t2_req_low2", {31'd0, imem_req}, 32'd0);
    tick();
    chk("t2_hold2", {16'd0, ifid_pc2}, 32'h0006);
    stall_id = 1'b0;
    drain("t2_drain", 40);

    // 3: slow memory, redirect while busy
    lat = 4;
    do_reset();
    push_seq(16'h0100, 3);
    tick();
    tick();
    redirect_pc = 16'h0100;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    wait_new_req("t3", 20);
    chk("t3_new_addr", {16'd0, imem_addr}, 32'h0100);
    drain("t3_drain", 60);

    // 4: HALT at 0x0008, then redirect to 0x0020
    lat = 0;
    fill_mem(1'b1);
    mem[4] = 16'h0000;
    do_reset();
    push_seq(16'h0000, 5);
    drain("t4_drain", 20);
    chk("t4_halted", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_req", {31'd0, imem_req}, 32'd0);
    end
    push_seq(16'h0020, 3);
    redirect_pc = 16'h0020;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("t4_unhalt", {31'd0, halted}, 32'd0);
    wait_new_req("t4", 10);
    chk("t4_resume_addr", {16'd0, imem_addr}, 32'h0020);
    drain("t4_drain2", 20);

    // 5: PC wrap on the RESET_PC=FFFE instance
    do_reset();
    tick();
    chk("t5_addr", {15'd0, req_w, addr_w}, {15'd0, 1'b1, 16'hFFFE});
    tick();
    chk("t5_valid", {31'd0, valid_w}, 32'd1);
    chk("t5_pc2", {16'd0, pc2_w}, 32'h0000);
    chk("t5_next_addr", {16'd0, addr_w}, 32'h0000);
    chk("t5_instr", {16'd0, instr_w}, 32'h4000);
    chk("t5_opc", {27'd0, opc_w}, {27'd0, 5'b01000});
    chk("t5_halted", {31'd0, halted_w}, 32'd0);

    // 6: asynchronous reset while a request is outstanding
    lat = 1;
    fill_mem(1'b1);
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = ifid_valid && imem_req && !imem_ready;
    end
    chk("t6_busy_seen", {31'd0, found}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_req_async", {31'd0, imem_req}, 32'd0);
    chk("t6_valid_async", {31'd0, ifid_valid}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_refetch", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'h0000});

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
